// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl: IE/IF/IME interrupt controller and the
// 5 M-cycle interrupt dispatch sequencer for the SM83 core.
module sm83_irq_ctl #(
    parameter int NUM_IRQ = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_tick,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               if_wr,
    input  logic               ie_wr,
    input  logic [7:0]         wdata,
    output logic [7:0]         if_q,
    output logic [7:0]         ie_q,
    input  logic               instr_boundary,
    input  logic               ctl_di,
    input  logic               ctl_ei,
    input  logic               ctl_reti,
    input  logic               ctl_halt,
    input  logic [15:0]        pc,
    output logic               irq_take,
    output logic               halted,
    output logic               dispatch,
    output logic               push_en,
    output logic [7:0]         push_data,
    output logic               pc_load,
    output logic [15:0]        vec,
    output logic               ime
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HALT = 3'd1;
    localparam logic [2:0] S_D1   = 3'd2;
    localparam logic [2:0] S_D2   = 3'd3;
    localparam logic [2:0] S_D3   = 3'd4;
    localparam logic [2:0] S_D4   = 3'd5;
    localparam logic [2:0] S_D5   = 3'd6;

    logic [2:0]         r_state;
    logic [7:0]         r_ie;
    logic [NUM_IRQ-1:0] r_if;
    logic               r_ime;
    logic               r_ei_pend;
    logic               r_ei_go;
    logic [15:0]        r_vec;

    logic [NUM_IRQ-1:0] w_pend_vec;
    logic               w_pending;
    logic               w_take;
    logic [NUM_IRQ-1:0] w_sel_oh;
    logic [15:0]        w_sel_vec;
    logic [NUM_IRQ-1:0] w_if_nxt;
    logic               w_d4_tick;

    assign w_pend_vec = r_ie[NUM_IRQ-1:0] & r_if;
    assign w_pending  = |w_pend_vec;
    assign w_take     = (r_state == S_IDLE) & instr_boundary
                      & r_ime & w_pending;
    assign w_d4_tick  = m_tick & (r_state == S_D4);

    // Lowest set bit wins: scan from the top so bit 0 lands last.
    always_comb begin
        w_sel_oh  = '0;
        w_sel_vec = 16'h0000;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend_vec[i]) begin
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_vec   = 16'(16'h0040 + 8 * i);
            end
        end
    end

    // Request beats bus write, which beats the dispatch clear.
    always_comb begin
        w_if_nxt = r_if;
        if (w_d4_tick)
            w_if_nxt = w_if_nxt & ~w_sel_oh;
        if (if_wr)
            w_if_nxt = wdata[NUM_IRQ-1:0];
        w_if_nxt = w_if_nxt | irq_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie <= 8'h00;
            r_if <= '0;
        end else begin
            if (ie_wr)
                r_ie <= wdata;
            r_if <= w_if_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
            r_ei_go   <= 1'b0;
        end else if (m_tick) begin
            if (w_take || ctl_di) begin
                r_ime     <= 1'b0;
                r_ei_pend <= 1'b0;
                r_ei_go   <= 1'b0;
            end else begin
                if (instr_boundary) begin
                    r_ei_pend <= ctl_ei;
                    r_ei_go   <= r_ei_pend;
                end else begin
                    r_ei_pend <= r_ei_pend | ctl_ei;
                end
                if (ctl_reti || (instr_boundary && r_ei_go))
                    r_ime <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (m_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take)
                        r_state <= S_D1;
                    else if (ctl_halt && !w_pending)
                        r_state <= S_HALT;
                end
                S_HALT: if (w_pending) r_state <= S_IDLE;
                S_D1:   r_state <= S_D2;
                S_D2:   r_state <= S_D3;
                S_D3:   r_state <= S_D4;
                S_D4:   r_state <= S_D5;
                S_D5:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vec <= 16'h0000;
        else if (w_d4_tick)
            r_vec <= w_sel_vec;
    end

    always_comb begin
        if_q              = 8'hFF;
        if_q[NUM_IRQ-1:0] = r_if;
    end

    always_comb begin
        push_data = 8'h00;
        if (r_state == S_D3)
            push_data = pc[15:8];
        else if (r_state == S_D4)
            push_data = pc[7:0];
    end

    assign ie_q     = r_ie;
    assign irq_take = w_take;
    assign halted   = (r_state == S_HALT);
    assign dispatch = (r_state >= S_D1) && (r_state <= S_D5);
    assign push_en  = (r_state == S_D3) || (r_state == S_D4);
    assign pc_load  = (r_state == S_D5);
    assign vec      = r_vec;
    assign ime      = r_ime;

endmodule
